// File: rtl/aes_pkg.sv
// Shared definitions for the AES round controller slice.
//   ctrl_state_t    : controller FSM states (explicit 3-bit encoding)
//   AES_BLOCK_BYTES : bytes per AES block
//   AES128_NR       : cipher rounds for AES-128
//   MODE_ENC/DEC    : operation mode encoding
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    KEY   = 3'd2,
    ROUND = 3'd3,
    OUT   = 3'd4
  } ctrl_state_t;

  localparam int   AES_BLOCK_BYTES = 16;
  localparam int   AES128_NR       = 10;
  localparam logic MODE_ENC        = 1'b0;
  localparam logic MODE_DEC        = 1'b1;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Bundle of every handshake/strobe signal around the AES round controller.
//   master : the controller side (drives strobes, requests, status)
//   slave  : the environment side (host, key schedule, state datapath)
interface aes_round_ctrl_if;

  logic       start;
  logic       mode;
  logic       abort;
  logic       in_valid;
  logic       in_ready;
  logic       st_valid;
  logic       st_mode;
  logic       st_ready;
  logic       st_wen;
  logic       rk_req;
  logic [3:0] rk_idx;
  logic       rk_ack;
  logic [3:0] round;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_idx;
  logic       busy;
  logic       done;

  modport master (
    input  start, mode, abort, in_valid, st_ready, rk_ack, out_ready,
    output in_ready, st_valid, st_mode, st_wen, rk_req, rk_idx, round,
           out_valid, out_idx, busy, done
  );

  modport slave (
    output start, mode, abort, in_valid, st_ready, rk_ack, out_ready,
    input  in_ready, st_valid, st_mode, st_wen, rk_req, rk_idx, round,
           out_valid, out_idx, busy, done
  );

endinterface

// File: rtl/aes_byte_cnt.sv
// 4-bit byte counter with synchronous clear (priority over enable) and a
// wrap flag that is high while the count sits on LAST.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return count to 0
//   en         : advance count (LAST wraps to 0)
//   cnt        : current count
//   wrap       : count == LAST
module aes_byte_cnt
  import aes_pkg::*;
#(
  parameter logic [3:0] LAST = 4'(AES_BLOCK_BYTES - 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] cnt,
  output logic       wrap
);

  logic [3:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= (cnt_reg == LAST) ? 4'd0 : cnt_reg + 4'd1;
    end
  end

  assign cnt  = cnt_reg;
  assign wrap = (cnt_reg == LAST);

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencing controller for the AES state register and round datapath.
// Loads 16 host bytes, walks rounds 0..NR (key request, then ROUND_LAT
// datapath cycles ending in a single st_wen), then unloads 16 result bytes.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : handshake bundle (master side), see aes_round_ctrl_if
// Parameters:
//   NR        : number of cipher rounds
//   ROUND_LAT : datapath cycles per round before dnext is valid (>= 1)
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR        = AES128_NR,
  parameter int ROUND_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  aes_round_ctrl_if.master bus
);

  localparam int                 LAT_W    = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;
  localparam logic [LAT_W-1:0]   LAT_LAST = LAT_W'(ROUND_LAT - 1);
  localparam logic [3:0]         NR_L     = 4'(NR);

  ctrl_state_t      state_reg, state_next;
  logic [3:0]       round_reg, round_next;
  logic [LAT_W-1:0] lat_reg, lat_next;
  logic             mode_reg;
  logic             done_reg;

  // Byte counters: index 0 counts LOAD bytes, index 1 is the OUT byte index.
  logic [3:0] cnt_arr  [2];
  logic       wrap_arr [2];
  logic       clr_arr  [2];
  logic       en_arr   [2];

  logic byte_take;
  logic out_hs;
  logic round_last;
  logic start_ok;

  assign byte_take  = (state_reg == LOAD) && bus.in_valid;
  assign out_hs     = (state_reg == OUT) && bus.out_ready;
  assign round_last = (state_reg == ROUND) && (lat_reg == LAT_LAST);
  assign start_ok   = (state_reg == IDLE) && bus.start && !bus.abort;

  // Counters are held at zero outside their own state, so each entry
  // into LOAD/OUT starts from byte 0 without extra bookkeeping.
  assign clr_arr[0] = (state_reg != LOAD) || bus.abort;
  assign en_arr[0]  = byte_take;
  assign clr_arr[1] = (state_reg != OUT) || bus.abort;
  assign en_arr[1]  = out_hs;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      aes_byte_cnt u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_arr[gi]),
        .en    (en_arr[gi]),
        .cnt   (cnt_arr[gi]),
        .wrap  (wrap_arr[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    round_next = round_reg;
    lat_next   = lat_reg;
    if (bus.abort && (state_reg != IDLE)) begin
      state_next = IDLE;
      round_next = '0;
      lat_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            state_next = LOAD;
            round_next = '0;
          end
        end
        LOAD: begin
          // wrap_arr[0] with a byte taken means this is the 16th byte
          if ((byte_take && wrap_arr[0]) || bus.st_ready) begin
            state_next = KEY;
            round_next = '0;
          end
        end
        KEY: begin
          if (bus.rk_ack) begin
            state_next = ROUND;
            lat_next   = '0;
          end
        end
        ROUND: begin
          if (lat_reg == LAT_LAST) begin
            lat_next = '0;
            if (round_reg >= NR_L) begin
              state_next = OUT;
            end else begin
              round_next = round_reg + 4'd1;
              state_next = KEY;
            end
          end else begin
            lat_next = lat_reg + LAT_W'(1);
          end
        end
        OUT: begin
          if (out_hs && wrap_arr[1]) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      round_reg <= '0;
      lat_reg   <= '0;
      mode_reg  <= MODE_ENC;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      round_reg <= round_next;
      lat_reg   <= lat_next;
      if (start_ok) begin
        mode_reg <= bus.mode;
      end
      // abort in the final handshake cycle suppresses done
      done_reg <= out_hs && wrap_arr[1] && !bus.abort;
    end
  end

  assign bus.in_ready  = (state_reg == LOAD);
  assign bus.st_valid  = byte_take;
  assign bus.st_mode   = mode_reg;
  // an abort landing on the write cycle must not corrupt the state register
  assign bus.st_wen    = round_last && !bus.abort;
  assign bus.rk_req    = (state_reg == KEY);
  assign bus.rk_idx    = (state_reg != KEY)     ? 4'd0 :
                         (mode_reg == MODE_DEC) ? (NR_L - round_reg) : round_reg;
  assign bus.round     = round_reg;
  assign bus.out_valid = (state_reg == OUT);
  assign bus.out_idx   = cnt_arr[1];
  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl. Two instances (ROUND_LAT=1 and
// ROUND_LAT=3) share stimulus; only the selected one receives start.
// A monitor scores each operation at transaction level (byte counts, key
// index sequence, write spacing, unload order, done timing) against values
// derived from the round rules.
module tb_aes_round_ctrl;

  localparam int NR = 10;

  typedef struct {
    bit lat3;
    bit mode;
    bit in_rand;
    int ack_d;        // cycles rk_req is held per request; 0 = random 1..4
    int out_pat;      // 0 = always ready, 1 = 1,0,0 repeating, 2 = random
    int abort_wen;    // abort once this many st_wen seen; 0 = never
    int st_ready_at;  // raise st_ready once this many bytes taken; 0 = never
    int exp_stv;
    int exp_req;      // expected rk_req cycles; 0 = not checked
  } scen_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic sel = 1'b0;
  logic start = 1'b0, mode = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic st_ready = 1'b0, rk_ack = 1'b0, out_ready = 1'b0;

  aes_round_ctrl_if bus1();
  aes_round_ctrl_if bus3();

  aes_round_ctrl #(.NR(NR), .ROUND_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));
  aes_round_ctrl #(.NR(NR), .ROUND_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.master));

  assign bus1.start = start & ~sel;
  assign bus3.start = start & sel;
  assign bus1.mode = mode;           assign bus3.mode = mode;
  assign bus1.abort = abort;         assign bus3.abort = abort;
  assign bus1.in_valid = in_valid;   assign bus3.in_valid = in_valid;
  assign bus1.st_ready = st_ready;   assign bus3.st_ready = st_ready;
  assign bus1.rk_ack = rk_ack;       assign bus3.rk_ack = rk_ack;
  assign bus1.out_ready = out_ready; assign bus3.out_ready = out_ready;

  logic       o_in_ready, o_st_valid, o_st_mode, o_st_wen, o_rk_req;
  logic       o_out_valid, o_busy, o_done;
  logic [3:0] o_rk_idx, o_round, o_out_idx;

  assign o_in_ready  = sel ? bus3.in_ready  : bus1.in_ready;
  assign o_st_valid  = sel ? bus3.st_valid  : bus1.st_valid;
  assign o_st_mode   = sel ? bus3.st_mode   : bus1.st_mode;
  assign o_st_wen    = sel ? bus3.st_wen    : bus1.st_wen;
  assign o_rk_req    = sel ? bus3.rk_req    : bus1.rk_req;
  assign o_rk_idx    = sel ? bus3.rk_idx    : bus1.rk_idx;
  assign o_round     = sel ? bus3.round     : bus1.round;
  assign o_out_valid = sel ? bus3.out_valid : bus1.out_valid;
  assign o_out_idx   = sel ? bus3.out_idx   : bus1.out_idx;
  assign o_busy      = sel ? bus3.busy      : bus1.busy;
  assign o_done      = sel ? bus3.done      : bus1.done;

  int vectors = 0;
  int fails   = 0;

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int cyc = 0;
  int lat_cur = 1;
  logic exp_mode = 1'b0;
  int n_stv, n_req, n_wen, n_done, n_wen_post, n_req_post;
  int ack_cyc, hs_cyc, last_idx, prev_idx;
  bit prev_stall, post_abort, abort_prev;
  int rk_q[$];
  int rnd_q[$];
  int hs_q[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (o_st_valid) begin
        n_stv++;
        chk("st_valid_needs_in_valid", int'(in_valid & o_in_ready), 1);
      end
      if (o_busy) chk("st_mode", int'(o_st_mode), int'(exp_mode));
      if (o_rk_req) n_req++;
      if (o_rk_req && rk_ack) begin
        rk_q.push_back(int'(o_rk_idx));
        rnd_q.push_back(int'(o_round));
        ack_cyc = cyc;
      end
      if (o_st_wen) begin
        n_wen++;
        chk("wen_after_ack", cyc - ack_cyc, lat_cur);
        chk("wen_during_key", int'(o_rk_req), 0);
      end
      if (prev_stall && o_out_valid) chk("out_idx_hold", int'(o_out_idx), prev_idx);
      if (o_out_valid && out_ready) begin
        hs_q.push_back(int'(o_out_idx));
        hs_cyc = cyc;
        last_idx = int'(o_out_idx);
      end
      prev_stall = o_out_valid && !out_ready;
      prev_idx = int'(o_out_idx);
      if (o_done) begin
        n_done++;
        chk("done_after_last_hs", cyc - hs_cyc, 1);
        chk("done_last_idx", last_idx, 15);
      end
      if (post_abort) begin
        if (o_st_wen) n_wen_post++;
        if (o_rk_req) n_req_post++;
      end
      if (abort_prev) chk("abort_to_idle", int'(o_busy), 0);
      abort_prev = abort && o_busy;
      if (abort && o_busy) post_abort = 1'b1;
    end
  end

  task automatic clear_mon();
    n_stv = 0; n_req = 0; n_wen = 0; n_done = 0; n_wen_post = 0; n_req_post = 0;
    ack_cyc = -100; hs_cyc = -100; last_idx = -1; prev_idx = 0;
    prev_stall = 1'b0; post_abort = 1'b0; abort_prev = 1'b0;
    rk_q.delete(); rnd_q.delete(); hs_q.delete();
  endtask

  function automatic int pick_d(int ack_d);
    return (ack_d == 0) ? int'($urandom_range(1, 4)) : ack_d;
  endfunction

  // ---------------- one operation ----------------
  task automatic run(input int id, input scen_t s);
    int d, req_run, exp_wen, exp_hs, exp_done;
    bit abort_given, finished;
    clear_mon();
    sel = s.lat3; mode = s.mode; exp_mode = s.mode;
    lat_cur = s.lat3 ? 3 : 1;
    in_valid = 0; st_ready = 0; rk_ack = 0; out_ready = 0; abort = 0;
    d = pick_d(s.ack_d); req_run = 0; abort_given = 0; finished = 0;
    @(posedge clk); #1 start = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (!o_busy) begin
        finished = 1;
        break;
      end
      in_valid = s.in_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      st_ready = (s.st_ready_at != 0) && (n_stv >= s.st_ready_at);
      rk_ack = 1'b0;
      if (o_rk_req) begin
        if (req_run >= d - 1) begin
          rk_ack = 1'b1;
          req_run = 0;
          d = pick_d(s.ack_d);
        end else begin
          req_run++;
        end
      end
      case (s.out_pat)
        0:       out_ready = 1'b1;
        1:       out_ready = (k % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (s.abort_wen != 0 && !abort_given && n_wen >= s.abort_wen) begin
        abort = 1'b1;
        abort_given = 1;
      end else begin
        abort = 1'b0;
      end
    end
    in_valid = 0; rk_ack = 0; out_ready = 0; abort = 0; st_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    exp_wen  = (s.abort_wen != 0) ? s.abort_wen : NR + 1;
    exp_hs   = (s.abort_wen != 0) ? 0 : 16;
    exp_done = (s.abort_wen != 0) ? 0 : 1;
    chk("run_finished", int'(finished), 1);
    chk("n_st_valid", n_stv, s.exp_stv);
    chk("n_st_wen", n_wen, exp_wen);
    chk("n_handshakes", hs_q.size(), exp_hs);
    chk("n_done", n_done, exp_done);
    chk("wen_after_abort", n_wen_post, 0);
    chk("req_after_abort", n_req_post, 0);
    if (s.exp_req != 0) chk("n_rk_req_cycles", n_req, s.exp_req);
    if (s.abort_wen == 0) chk("n_rk_ack", rk_q.size(), NR + 1);
    foreach (rk_q[i]) begin
      if (i <= NR) begin
        chk("rk_idx_seq", rk_q[i], s.mode ? NR - i : i);
        chk("round_seq", rnd_q[i], i);
      end
    end
    foreach (hs_q[i]) chk("out_idx_seq", hs_q[i], i);
    chk("busy_after", int'(o_busy), 0);
    $display("op %0d: lat=%0d mode=%0d bytes=%0d keys=%0d wen=%0d out=%0d done=%0d",
             id, lat_cur, s.mode, n_stv, rk_q.size(), n_wen, hs_q.size(), n_done);
  endtask

  scen_t tbl[9];

  initial begin
    //        lat3 mode inr ackd outp abw str  stv req
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 16, 11};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 16, 11};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 3, 0, 0, 0, 16, 33};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 16, 11};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 3, 0, 0, 0, 16, 33};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1, 1, 0, 0, 16, 11};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1, 0, 5, 0, 16, 0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1, 0, 0, 8, 9, 11};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 0, 2, 0, 0, 16, 0};

    // reset values of both instances
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_in_ready", int'(o_in_ready), 0);
      chk("rst_st_wen", int'(o_st_wen), 0);
      chk("rst_rk_req", int'(o_rk_req), 0);
      chk("rst_rk_idx", int'(o_rk_idx), 0);
      chk("rst_round", int'(o_round), 0);
      chk("rst_out_valid", int'(o_out_valid), 0);
      chk("rst_out_idx", int'(o_out_idx), 0);
      chk("rst_st_mode", int'(o_st_mode), 0);
      chk("rst_done", int'(o_done), 0);
    end
    sel = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run(i, tbl[i]);

    // reset pulsed in the middle of LOAD, after 7 bytes
    clear_mon();
    sel = 1'b0; mode = 1'b1; exp_mode = 1'b1; in_valid = 1'b1;
    rk_ack = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 40 && n_stv < 7; i++) begin
      @(posedge clk); #1;
    end
    chk("midload_bytes", n_stv, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(o_busy), 0);
    chk("midrst_in_ready", int'(o_in_ready), 0);
    chk("midrst_st_valid", int'(o_st_valid), 0);
    chk("midrst_st_mode", int'(o_st_mode), 0);
    chk("midrst_round", int'(o_round), 0);
    chk("midrst_out_idx", int'(o_out_idx), 0);
    chk("midrst_done", int'(o_done), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    in_valid = 1'b0; rk_ack = 1'b0; out_ready = 1'b0;
    $display("op reset-mid-load: bytes=%0d before reset", n_stv);
    run(9, tbl[0]);

    // randomized operations
    for (int r = 0; r < 6; r++) begin
      scen_t rs;
      rs.lat3 = 1'($urandom_range(0, 1));
      rs.mode = 1'($urandom_range(0, 1));
      rs.in_rand = 1'b1;
      rs.ack_d = 0;
      rs.out_pat = 2;
      rs.abort_wen = 0;
      rs.st_ready_at = 0;
      rs.exp_stv = 16;
      rs.exp_req = 0;
      run(10 + r, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
